// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: add/sub in one step, shift-add multiply and restoring divide/modulus
// one bit per cycle, behind a start/busy/done handshake with registered Result and Error.
module seq_alu_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         OpCode,
    input  logic [WIDTH-1:0]   InputA,
    input  logic [WIDTH-1:0]   InputB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Result,
    output logic [1:0]         Error
);

    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpSub = 4'b0101;
    localparam logic [3:0] OpMul = 4'b0110;
    localparam logic [3:0] OpDiv = 4'b0111;
    localparam logic [3:0] OpMod = 4'b1000;
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} stateE;

    stateE              stateQ;
    logic [3:0]         opQ;
    logic [WIDTH-1:0]   aQ;
    logic [WIDTH-1:0]   bQ;
    logic [CntW-1:0]    cntQ;
    logic [2*WIDTH-1:0] prodQ;
    logic [WIDTH-1:0]   remQ;
    logic [WIDTH-1:0]   quoQ;

    logic [WIDTH-1:0]   bOp;
    logic [WIDTH:0]     fullSum;
    logic               carryIn;
    logic               ovf;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] finResult;
    logic [1:0]         finError;

    always_comb begin
        bOp      = (opQ == OpSub) ? ~bQ : bQ;
        fullSum  = {1'b0, aQ} + {1'b0, bOp} + {{WIDTH{1'b0}}, (opQ == OpSub)};
        // Carry into the MSB is recovered from the MSB sum bit and the operand MSBs.
        carryIn  = fullSum[WIDTH-1] ^ aQ[WIDTH-1] ^ bOp[WIDTH-1];
        ovf      = carryIn ^ fullSum[WIDTH];
        mulSum   = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + (prodQ[0] ? {1'b0, aQ} : '0);
        divShift = {remQ, quoQ[WIDTH-1]};
        divDiff  = divShift - {1'b0, bQ};

        finResult = '0;
        finError  = 2'b00;
        case (opQ)
            OpAdd, OpSub: begin
                finResult = {{WIDTH{fullSum[WIDTH-1]}}, fullSum[WIDTH-1:0]};
                finError  = {1'b0, ovf};
            end
            OpMul: finResult = prodQ;
            OpDiv: begin
                if (bQ == '0) begin
                    finResult = '1;
                    finError  = 2'b10;
                end else begin
                    finResult = {{WIDTH{1'b0}}, quoQ};
                end
            end
            OpMod: begin
                if (bQ == '0) begin
                    finResult = {{WIDTH{1'b0}}, aQ};
                    finError  = 2'b10;
                end else begin
                    finResult = {{WIDTH{1'b0}}, remQ};
                end
            end
            default: finError = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            opQ    <= '0;
            aQ     <= '0;
            bQ     <= '0;
            cntQ   <= '0;
            prodQ  <= '0;
            remQ   <= '0;
            quoQ   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            Error  <= 2'b00;
        end else begin
            case (stateQ)
                StIdle: begin
                    done <= 1'b0;
                    // A start during the done cycle is dropped.
                    if (start && !done) begin
                        opQ   <= OpCode;
                        aQ    <= InputA;
                        bQ    <= InputB;
                        cntQ  <= CntW'(WIDTH - 1);
                        prodQ <= {{WIDTH{1'b0}}, InputB};
                        remQ  <= '0;
                        quoQ  <= InputA;
                        busy  <= 1'b1;
                        if (OpCode == OpMul) begin
                            stateQ <= StMul;
                        end else if ((OpCode == OpDiv || OpCode == OpMod) && InputB != '0) begin
                            stateQ <= StDiv;
                        end else begin
                            stateQ <= StFin;
                        end
                    end
                end
                StMul: begin
                    prodQ <= {mulSum, prodQ[WIDTH-1:1]};
                    cntQ  <= cntQ - 1'b1;
                    if (cntQ == '0) stateQ <= StFin;
                end
                StDiv: begin
                    if (divDiff[WIDTH]) begin
                        remQ <= divShift[WIDTH-1:0];
                        quoQ <= {quoQ[WIDTH-2:0], 1'b0};
                    end else begin
                        remQ <= divDiff[WIDTH-1:0];
                        quoQ <= {quoQ[WIDTH-2:0], 1'b1};
                    end
                    cntQ <= cntQ - 1'b1;
                    if (cntQ == '0) stateQ <= StFin;
                end
                StFin: begin
                    Result <= finResult;
                    Error  <= finError;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    stateQ <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: cycle-accurate behavioural model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_seq_alu_core;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    OpCode;
    logic [W-1:0]  InputA;
    logic [W-1:0]  InputB;
    logic          busy;
    logic          done;
    logic [2*W-1:0] Result;
    logic [1:0]    Error;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    logic           mBusy = 1'b0;
    logic           mDone = 1'b0;
    logic [2*W-1:0] mRes = '0;
    logic [1:0]     mErr = 2'b00;
    logic [2*W-1:0] pendRes = '0;
    logic [1:0]     pendErr = 2'b00;
    int             remaining = 0;

    seq_alu_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .OpCode (OpCode),
        .InputA (InputA),
        .InputB (InputB),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Error  (Error)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] modelRes(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] s;
        case (op)
            4'd4, 4'd5: begin
                s = (op == 4'd4) ? a + b : a - b;
                return {{W{s[W-1]}}, s};
            end
            4'd6: return (2*W)'(a) * (2*W)'(b);
            4'd7: return (b == 0) ? '1 : (2*W)'(a / b);
            4'd8: return (b == 0) ? (2*W)'(a) : (2*W)'(a % b);
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] modelErr(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        int sa;
        int sb;
        int t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd4, 4'd5: begin
                t = (op == 4'd4) ? sa + sb : sa - sb;
                return (t > 32767 || t < -32768) ? 2'b01 : 2'b00;
            end
            4'd6: return 2'b00;
            4'd7, 4'd8: return (b == 0) ? 2'b10 : 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int modelLat(logic [3:0] op, logic [W-1:0] b);
        if (op == 4'd6) return W + 1;
        if ((op == 4'd7 || op == 4'd8) && b != 0) return W + 1;
        return 1;
    endfunction

    // Transaction-level model: count down the latency, then show the result for one cycle.
    always @(posedge clk) begin
        if (rst) begin
            mBusy     <= 1'b0;
            mDone     <= 1'b0;
            mRes      <= '0;
            mErr      <= 2'b00;
            remaining <= 0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mBusy) begin
            if (remaining == 1) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
                mRes  <= pendRes;
                mErr  <= pendErr;
            end
            remaining <= remaining - 1;
        end else if (start) begin
            pendRes   <= modelRes(OpCode, InputA, InputB);
            pendErr   <= modelErr(OpCode, InputA, InputB);
            remaining <= modelLat(OpCode, InputB);
            mBusy     <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            tests++;
            if (busy !== mBusy || done !== mDone || Result !== mRes || Error !== mErr) begin
                fails++;
                $display("FAIL cycle@%0t: got busy=%b done=%b Result=%h Error=%b, expected busy=%b done=%b Result=%h Error=%b",
                         $time, busy, done, Result, Error, mBusy, mDone, mRes, mErr);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge where a new start is accepted.
    task automatic doOp(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit noisy, input bit lit,
                        input logic [2*W-1:0] eRes, input logic [1:0] eErr, input int eLat);
        int k;
        OpCode = op;
        InputA = a;
        InputB = b;
        start  = 1'b1;
        @(negedge clk);
        if (noisy) begin
            OpCode = 4'b0100;
            InputA = W'($urandom);
            InputB = W'($urandom);
        end else begin
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            check({name, " timeout"}, 64'(done), 64'd1);
        end else if (lit) begin
            check({name, " Result"}, 64'(Result), 64'(eRes));
            check({name, " Error"}, 64'(Error), 64'(eErr));
            check({name, " latency"}, 64'(k), 64'(eLat));
        end
        @(negedge clk);
        start = 1'b0;
        if (lit) check({name, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst    = 1'b1;
        start  = 1'b0;
        OpCode = '0;
        InputA = '0;
        InputB = '0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset Result", 64'(Result), 64'd0);
        check("reset Error", 64'(Error), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        doOp("add100+150", 4'b0100, 16'd100, 16'd150, 1'b0, 1'b1, 32'd250, 2'b00, 1);
        doOp("add ovf", 4'b0100, 16'h4844, 16'h52EE, 1'b0, 1'b1, 32'hFFFF9B32, 2'b01, 1);
        doOp("sub ovf", 4'b0101, 16'hC000, 16'h6000, 1'b0, 1'b1, 32'h00006000, 2'b01, 1);
        doOp("mul", 4'b0110, 16'd477, 16'd116, 1'b0, 1'b1, 32'd55332, 2'b00, 17);
        doOp("mul by 0", 4'b0110, 16'h5802, 16'd0, 1'b0, 1'b1, 32'd0, 2'b00, 17);
        doOp("div", 4'b0111, 16'd29450, 16'd16450, 1'b0, 1'b1, 32'd1, 2'b00, 17);
        doOp("mod", 4'b1000, 16'd29450, 16'd16450, 1'b0, 1'b1, 32'd13000, 2'b00, 17);
        doOp("mod exact", 4'b1000, 16'd32400, 16'd16200, 1'b0, 1'b1, 32'd0, 2'b00, 17);
        doOp("div by 0", 4'b0111, 16'd21, 16'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 2'b10, 1);
        doOp("mod by 0", 4'b1000, 16'd169, 16'd0, 1'b0, 1'b1, 32'd169, 2'b10, 1);
        doOp("illegal", 4'b0000, 16'd5, 16'd7, 1'b0, 1'b1, 32'd0, 2'b11, 1);
        doOp("mul noisy start", 4'b0110, 16'd477, 16'd116, 1'b1, 1'b1, 32'd55332, 2'b00, 17);
        doOp("div noisy start", 4'b0111, 16'd29450, 16'd16450, 1'b1, 1'b1, 32'd1, 2'b00, 17);

        for (int i = 0; i < 250; i++) begin
            op = 4'(4 + $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) op = 4'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 7) == 0) b = W'($urandom_range(1, 20));
            doOp("random", op, a, b, ($urandom_range(0, 3) == 0), 1'b0, '0, 2'b00, 0);
        end

        // Abort a multiply with reset at N+5.
        OpCode = 4'b0110;
        InputA = 16'd1234;
        InputB = 16'd4321;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort Result", 64'(Result), 64'd0);
        check("abort Error", 64'(Error), 64'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        doOp("add after abort", 4'b0101, 16'd10, 16'd3, 1'b0, 1'b1, 32'd7, 2'b00, 1);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu_core.md
# seq_alu_core

Parametrised, multi-cycle successor to the combinational 16-bit breadboard ALU. It keeps the same opcode map (add, subtract, multiply, divide, modulus) and the same 2-bit error encoding. It adds a start/busy/done handshake, iterative shift-add multiply, restoring divide and modulus, registered outputs, and illegal-opcode reporting. It sits between the operand registers and the result bus and is driven by a sequencer that issues one operation at a time.

## Interface
- WIDTH, 16, operand width in bits; Result is 2*WIDTH bits. Legal range 4..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0 and done=0.
- OpCode  in  4  0100 add, 0101 sub, 0110 mul, 0111 div, 1000 mod; every other code is illegal.
- InputA  in  WIDTH  operand A; latched on the accepting edge.
- InputB  in  WIDTH  operand B; latched on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; Result and Error are valid from this cycle on.
- Result  out  2*WIDTH  registered result.
- Error  out  2  bit0 = signed add/sub overflow, bit1 = divide by zero; 2'b11 = illegal opcode.

## Operation
- FSM states:
  - IDLE: start=1 latches OpCode, A and B.
    - add, sub, illegal opcode, or div/mod with B=0 → FIN.
    - mul → MUL; div/mod with B≠0 → DIV.
  - MUL: WIDTH iterations, one bit per cycle, then → FIN.
  - DIV: WIDTH iterations, one bit per cycle, then → FIN.
  - FIN: writes Result and Error, pulses done, → IDLE.
- add/sub:
  - WIDTH-bit two's-complement sum A+B or A−B; subtract is A + ~B + 1.
  - Result is the sum sign-extended to 2*WIDTH.
  - Error[0] = carry into MSB XOR carry out of MSB.
- mul: unsigned A×B, full 2*WIDTH-bit product, Error=00.
- div/mod:
  - Unsigned restoring division.
  - Quotient (div) or remainder (mod), zero-extended to 2*WIDTH, Error=00.
- Divide by zero: Error=2'b10.
  - div: Result = all ones.
  - mod: Result = A, zero-extended.
- Illegal opcode: Result = 0, Error = 2'b11.
- Result and Error hold their values until the next FIN; they are never cleared at start.
- start while busy=1 or done=1 is ignored. OpCode, A and B are don't-care outside the accepting edge.

## Timing
- Reset values: busy=0, done=0, Result=0, Error=00, state IDLE. rst has priority over start.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs return to their reset values on that same edge.
- Let N be the edge that accepts start. busy=1 from after edge N until edge N+L. At edge N+L: done=1, busy=0, Result and Error updated.
- L values:
  - add, sub, illegal opcode, divide-by-zero: L=1.
  - mul, div, mod (B≠0): L=WIDTH+1.
- done drops at edge N+L+1.
- A start presented during the done cycle is ignored. The earliest next accept is edge N+L+2, so throughput is one operation per L+2 cycles.

## Test plan
All scenarios use WIDTH=16.
- add A=100, B=150 at edge N → at N+1: done=1, Result=250, Error=00; at N+2: done=0.
- add A=0x4844, B=0x52EE → Result=0xFFFF9B32, Error=01. sub A=0xC000, B=0x6000 → Result=0x00006000, Error=01. L=1 for both.
- mul A=477, B=116 → busy high across edges N..N+16; at N+17: Result=55332 (0x0000D824), Error=00. mul A=0x5802, B=0 → Result=0.
- div A=29450, B=16450 → Result=1 at N+17. mod with the same operands → Result=13000. mod A=32400, B=16200 → Result=0.
- div A=21, B=0 → at N+1: Result=0xFFFFFFFF, Error=10. mod A=169, B=0 → Result=169, Error=10.
- Abort, ignore and illegal cases:
  - rst at N+5 of a mul → busy=0, Result=0, no done pulse.
  - A second start asserted while busy → ignored; the first result is unchanged.
  - OpCode 0000 → at N+1: Result=0, Error=11.
